// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle integer divide/remainder unit for the EX stage.
// One restoring-division step per cycle on unsigned magnitudes, with the
// sign fixed up on the way into DONE. Divide-by-zero and signed overflow
// skip the iteration and go straight to DONE.
module ex_div_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] operand1_i,
  input  logic [DATA_WIDTH-1:0] operand2_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
  logic                  is_rem_q, is_rem_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  // Operand decode, special-case detection and one division step.
  logic                  op_is_div_s;
  logic                  op_is_signed_s;
  logic [DATA_WIDTH-1:0] a_mag_s;
  logic [DATA_WIDTH-1:0] b_mag_s;
  logic                  div_zero_s;
  logic                  overflow_s;
  logic                  special_s;
  logic [DATA_WIDTH-1:0] special_res_s;
  logic [DATA_WIDTH:0]   r_shift_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic [DATA_WIDTH-1:0] step_rem_s;
  logic [DATA_WIDTH-1:0] step_quo_s;
  logic [DATA_WIDTH-1:0] final_res_s;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= {CW{1'b0}};
      rem_q     <= ZERO;
      quo_q     <= ZERO;
      dvsr_q    <= ZERO;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= ZERO;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  // Decode the op, form magnitudes, and evaluate one restoring step.
  always_comb begin
    op_is_div_s    = (funct3_i == 3'b100) || (funct3_i == 3'b101);
    op_is_signed_s = (funct3_i == 3'b100) || (funct3_i == 3'b110);
    a_mag_s = (op_is_signed_s && operand1_i[DATA_WIDTH-1]) ? -operand1_i : operand1_i;
    b_mag_s = (op_is_signed_s && operand2_i[DATA_WIDTH-1]) ? -operand2_i : operand2_i;
    div_zero_s = (operand2_i == ZERO);
    overflow_s = op_is_signed_s && (operand1_i == MIN_NEG) && (operand2_i == ALL_ONES);
    special_s  = div_zero_s || overflow_s;
    if (div_zero_s) begin
      special_res_s = op_is_div_s ? ALL_ONES : operand1_i;
    end else begin
      special_res_s = op_is_div_s ? operand1_i : ZERO;
    end

    // Shift the next dividend bit into the partial remainder and try to subtract.
    r_shift_s = {rem_q, quo_q[DATA_WIDTH-1]};
    diff_s    = r_shift_s - {1'b0, dvsr_q};
    if (!diff_s[DATA_WIDTH]) begin
      step_rem_s = diff_s[DATA_WIDTH-1:0];
      step_quo_s = {quo_q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      step_rem_s = r_shift_s[DATA_WIDTH-1:0];
      step_quo_s = {quo_q[DATA_WIDTH-2:0], 1'b0};
    end

    if (is_rem_q) begin
      final_res_s = neg_rem_q ? -step_rem_s : step_rem_s;
    end else begin
      final_res_s = neg_quo_q ? -step_quo_s : step_quo_s;
    end
  end

  // Next-state logic plus datapath register updates.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (start_i) begin
          rem_d     = ZERO;
          quo_d     = a_mag_s;
          dvsr_d    = b_mag_s;
          count_d   = {CW{1'b0}};
          is_rem_d  = !op_is_div_s;
          neg_quo_d = op_is_signed_s && (operand1_i[DATA_WIDTH-1] ^ operand2_i[DATA_WIDTH-1]);
          neg_rem_d = op_is_signed_s && operand1_i[DATA_WIDTH-1];
          if (special_s) begin
            state_d  = DONE;
            result_d = special_res_s;
          end else begin
            state_d  = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
          count_d = {CW{1'b0}};
        end else begin
          rem_d   = step_rem_s;
          quo_d   = step_quo_s;
          count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
          if (count_q == LAST_CNT) begin
            state_d  = DONE;
            result_d = final_res_s;
          end else begin
            state_d  = CALC;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = {CW{1'b0}};
      end
    endcase
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  // Outputs: stall is combinational so the pipeline freezes in the accept cycle.
  always_comb begin
    stall_o  = ((state_q == IDLE) && start_i && !flush_i) || (state_q == CALC);
    busy_o   = busy_q;
    valid_o  = valid_q;
    result_o = result_q;
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: table-driven directed checks of ex_div_ctrl plus
// hand-written flush and reset-during-CALC sequences.
module tb_ex_div_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] operand1_i;
  logic [31:0] operand2_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          stall;
  } vec_t;

  vec_t vecs[16];
  logic [31:0] last_res;

  ex_div_ctrl #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge, hold start until valid, then check latency and result.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int exp_stall);
    int  stalls;
    bit  seen;
    stalls = 0;
    seen   = 1'b0;
    @(negedge clk);
    start_i    = 1'b1;
    funct3_i   = f3;
    operand1_i = a;
    operand2_i = b;
    #1;
    for (int c = 0; c < 100; c++) begin
      if (c == 1) chk({name, "_busy_after_accept"}, {31'd0, busy_o}, 32'd1);
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
      if (stall_o) stalls++;
      @(negedge clk);
    end
    start_i = 1'b0;
    chk({name, "_valid_seen"}, {31'd0, seen}, 32'd1);
    chk({name, "_stall_cycles"}, stalls, exp_stall);
    chk({name, "_result"}, result_o, res);
    chk({name, "_stall_in_done"}, {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    chk({name, "_valid_one_cycle"}, {31'd0, valid_o}, 32'd0);
    chk({name, "_busy_dropped"}, {31'd0, busy_o}, 32'd0);
    chk({name, "_result_held"}, result_o, res);
    last_res = res;
  endtask

  initial begin
    int vcount;

    vecs[0]  = '{3'b101, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{3'b111, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{3'b110, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33};
    vecs[3]  = '{3'b100, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33};
    vecs[4]  = '{3'b100, 32'd5,          32'd0,          32'hFFFFFFFF,   1};
    vecs[5]  = '{3'b111, 32'd5,          32'd0,          32'd5,          1};
    vecs[6]  = '{3'b100, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
    vecs[7]  = '{3'b110, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
    vecs[8]  = '{3'b101, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33};
    vecs[9]  = '{3'b111, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33};
    vecs[10] = '{3'b100, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   33};
    vecs[11] = '{3'b110, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   33};
    vecs[12] = '{3'b100, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         33};
    vecs[13] = '{3'b000, 32'd100,        32'd7,          32'd2,          33};
    vecs[14] = '{3'b101, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33};
    vecs[15] = '{3'b110, 32'd5,          32'd0,          32'd5,          1};

    rst_n      = 1'b0;
    start_i    = 1'b0;
    funct3_i   = 3'b000;
    operand1_i = 32'd0;
    operand2_i = 32'd0;
    flush_i    = 1'b0;
    last_res   = 32'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy",   {31'd0, busy_o},  32'd0);
    chk("rst_valid",  {31'd0, valid_o}, 32'd0);
    chk("rst_stall",  {31'd0, stall_o}, 32'd0);
    chk("rst_result", result_o,         32'd0);
    rst_n = 1'b1;

    // Table of directed vectors.
    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].stall);
    end

    // Flush in CALC cycle 10: back to IDLE, no valid, result untouched.
    @(negedge clk);
    start_i    = 1'b1;
    funct3_i   = 3'b101;
    operand1_i = 32'd1000;
    operand2_i = 32'd3;
    repeat (10) @(negedge clk);
    chk("flush_in_calc_stall", {31'd0, stall_o}, 32'd1);
    flush_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy",   {31'd0, busy_o},  32'd0);
    chk("flush_stall",  {31'd0, stall_o}, 32'd0);
    chk("flush_valid",  {31'd0, valid_o}, 32'd0);
    chk("flush_result", result_o,         last_res);
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      if (valid_o) vcount++;
      @(negedge clk);
    end
    chk("flush_no_late_valid", vcount, 32'd0);
    run_op("after_flush", 3'b101, 32'd1000, 32'd3, 32'd333, 33);

    // Reset in CALC cycle 5: outputs clear asynchronously, no valid after release.
    @(negedge clk);
    start_i    = 1'b1;
    funct3_i   = 3'b101;
    operand1_i = 32'd77;
    operand2_i = 32'd5;
    repeat (5) @(negedge clk);
    #2;
    rst_n   = 1'b0;
    start_i = 1'b0;
    #1;
    chk("calc_rst_busy",   {31'd0, busy_o},  32'd0);
    chk("calc_rst_valid",  {31'd0, valid_o}, 32'd0);
    chk("calc_rst_stall",  {31'd0, stall_o}, 32'd0);
    chk("calc_rst_result", result_o,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid_o || busy_o) vcount++;
    end
    chk("calc_rst_no_valid", vcount, 32'd0);

    // First start after reset release is accepted on the first edge.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("first_after_rst", 3'b100, 32'd100, 32'd7, 32'd14, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
